// File: rtl/mem_req_responder_if.sv
// Request/response bus between a requester (master) and mem_req_responder (slave).
interface mem_req_responder_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_req_responder.sv
// Memory request responder: one outstanding read/write at a time against a
// synchronous-read, write-first block RAM; one response per request.
// Optional MEM_RESP_BOUNDS_EN: addresses >= DEPTH complete with rsp_err=1,
// rsp_rdata=0 and no RAM write. Without it DEPTH must equal 2**ADDR_WIDTH.
module mem_req_responder #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DEPTH      = 1024
) (
  input logic            clk,
  input logic            rst,
  mem_req_responder_if.slave bus
);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t                state;
  state_t                stateNext;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ramQ;
  logic [DATA_WIDTH-1:0] rdataQ;
  logic                  accept;
  logic                  inRange;
  logic                  ramWe;
  logic [IDX_W-1:0]      ramIdx;

  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_rdata = rdataQ;
  assign accept        = bus.req_valid && (state == S_IDLE);
  assign ramIdx        = bus.req_addr[IDX_W-1:0];

`ifdef MEM_RESP_BOUNDS_EN
  logic errQ;
  logic rspErrQ;

  assign inRange     = (32'(bus.req_addr) < DEPTH);
  assign bus.rsp_err = rspErrQ;
`else
  assign inRange     = 1'b1;
  assign bus.rsp_err = 1'b0;
`endif

  // RAM access happens on the accepting edge, so only the range flag needs latching
  assign ramWe = accept && rst && bus.req_we && inRange;

  // Block RAM, write-first: a write returns its own data on q
  always_ff @(posedge clk) begin
    if (accept && rst) begin
      if (ramWe) begin
        mem[ramIdx] <= bus.req_wdata;
        ramQ        <= bus.req_wdata;
      end else begin
        ramQ <= mem[ramIdx];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= stateNext;
  end

  // FSM next-state logic
  always_comb begin
    stateNext = state;
    unique case (state)
      S_IDLE:   if (accept) stateNext = S_ACCESS;
      S_ACCESS: stateNext = S_RESP;
      S_RESP:   if (bus.rsp_ready) stateNext = S_IDLE;
      default:  stateNext = S_IDLE;
    endcase
  end

`ifdef MEM_RESP_BOUNDS_EN
  // Response registers: latch range flag on accept, capture RAM q in S_ACCESS
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdataQ  <= '0;
      errQ    <= 1'b0;
      rspErrQ <= 1'b0;
    end else if (accept) begin
      errQ <= !inRange;
    end else if (state == S_ACCESS) begin
      rdataQ  <= errQ ? '0 : ramQ;
      rspErrQ <= errQ;
    end
  end
`else
  // Response data register: capture RAM q in S_ACCESS, hold otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    rdataQ <= '0;
    else if (state == S_ACCESS)  rdataQ <= ramQ;
  end
`endif
endmodule

// File: tb/tb_mem_req_responder.sv
// Scoreboard testbench for mem_req_responder; build with +define+MEM_RESP_BOUNDS_EN
// to exercise out-of-range handling with DEPTH=512.
`timescale 1ns/1ps
module tb_mem_req_responder;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 10;
`ifdef MEM_RESP_BOUNDS_EN
  localparam int unsigned DEPTH = 512;
`else
  localparam int unsigned DEPTH = 1024;
`endif

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_req_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_req_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rsp_t          sb[$];
  logic [DW-1:0] model [1 << AW];
  logic [DW-1:0] lastRdata;
  int            checks   = 0;
  int            failures = 0;

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Response monitor: pop and compare on each response handshake
  always @(negedge clk) begin : monitor
    rsp_t e;
    if (rst && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        checkVal("sb_underflow", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        checkVal("rsp_rdata", bus.rsp_rdata, e.rdata);
        checkVal("rsp_err", bus.rsp_err, e.err);
        lastRdata = bus.rsp_rdata;
      end
    end
  end

  // Issue one request; returns at the negedge where rsp_valid first shows
  task automatic sendReq(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    rsp_t e;
    int   n;
    if (32'(addr) < DEPTH) begin
      if (we) model[addr] = wdata;
      e.rdata = we ? wdata : model[addr];
      e.err   = 1'b0;
    end else begin
      e.rdata = '0;
      e.err   = 1'b1;
    end
    sb.push_back(e);
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.req_ready) break;
    end
    checkVal("accept_wait", 32'(n < 20), 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_addr  = AW'($urandom);
    bus.req_wdata = DW'($urandom);
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (bus.rsp_valid) break;
    end
    checkVal("rsp_latency", n, 2);
  endtask

  // Wait for the response handshake to finish; req_ready must be back
  task automatic waitDone();
    int n;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (!bus.rsp_valid) break;
    end
    checkVal("done_wait", 32'(n < 50), 1);
    checkVal("req_ready_ret", bus.req_ready, 1);
  endtask

  task automatic doReq(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    sendReq(we, addr, wdata);
    waitDone();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("rst_rsp_valid", bus.rsp_valid, 0);
    checkVal("rst_rsp_rdata", bus.rsp_rdata, 0);
    checkVal("rst_rsp_err", bus.rsp_err, 0);
    checkVal("rst_req_ready", bus.req_ready, 1);
    @(posedge clk); #1;
    rst = 1'b1;

    // Write then read addr 0
    doReq(1'b1, 10'd0, 16'h1234);
    doReq(1'b0, 10'd0, 16'h0000);
    checkVal("rd0_value", lastRdata, 16'h1234);

    // Idle with req_valid=0 and garbage on the other inputs: nothing happens
    @(posedge clk); #1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 10'd0;
    bus.req_wdata = 16'hFFFF;
    repeat (4) begin
      @(negedge clk);
      checkVal("idle_req_ready", bus.req_ready, 1);
      checkVal("idle_rsp_valid", bus.rsp_valid, 0);
    end
    doReq(1'b0, 10'd0, 16'h0000);

    // Read-modify-write at 510, neighbour 511 untouched
    doReq(1'b1, 10'd511, 16'h7777);
    doReq(1'b1, 10'd510, 16'h0005);
    doReq(1'b0, 10'd510, 16'h0000);
    doReq(1'b1, 10'd510, lastRdata + 16'd3);
    doReq(1'b0, 10'd510, 16'h0000);
    checkVal("rmw_final", lastRdata, 16'h0008);
    doReq(1'b0, 10'd511, 16'h0000);

    // Backpressure on a read of addr 1
    doReq(1'b1, 10'd1, 16'h00C3);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    sendReq(1'b0, 10'd1, 16'h0000);
    repeat (5) begin
      @(negedge clk);
      checkVal("bp_rsp_valid", bus.rsp_valid, 1);
      checkVal("bp_rsp_rdata", bus.rsp_rdata, 16'h00C3);
      checkVal("bp_req_ready", bus.req_ready, 0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    waitDone();

    // Reset while a read response is pending
    doReq(1'b1, 10'd2, 16'hA5A5);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    sendReq(1'b0, 10'd2, 16'h0000);
    void'(sb.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkVal("mid_rst_rsp_valid", bus.rsp_valid, 0);
    checkVal("mid_rst_rsp_rdata", bus.rsp_rdata, 0);
    checkVal("mid_rst_req_ready", bus.req_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checkVal("post_rst_req_ready", bus.req_ready, 1);
    checkVal("post_rst_rsp_valid", bus.rsp_valid, 0);
    doReq(1'b0, 10'd2, 16'h0000);
    doReq(1'b0, 10'd0, 16'h0000);

`ifdef MEM_RESP_BOUNDS_EN
    // Out-of-range write is suppressed and flagged; aliased word unchanged
    doReq(1'b1, 10'd88, 16'h0088);
    doReq(1'b1, 10'd600, 16'hBEEF);
    doReq(1'b0, 10'd88, 16'h0000);
    checkVal("alias_88", lastRdata, 16'h0088);
    doReq(1'b0, 10'd1023, 16'h0000);
    doReq(1'b0, 10'd511, 16'h0000);
`endif

    // Random write/read-back pairs
    for (int i = 0; i < 8; i++) begin
      a = AW'($urandom_range(DEPTH - 1, 0));
      d = DW'($urandom);
      doReq(1'b1, a, d);
      doReq(1'b0, a, 16'h0000);
    end
    doReq(1'b0, 10'd0, 16'h0000);

    checkVal("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
